hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RISC-V core. It drives the stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, control redirects from branches and jumps, and data-memory wait states. A small FSM tracks memory waits, with a timeout error flag and hazard performance counters.

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard sources in,
// pipeline register stall/flush controls and perf counters out.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        ex_mem_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic        mem_timeout_err;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_memread, ex_rd, ex_redirect,
    output mem_req, mem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    input  if_id_flush, id_ex_flush, mem_wb_flush,
    input  mem_timeout_err, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_memread, ex_rd, ex_redirect,
    input  mem_req, mem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    output if_id_flush, id_ex_flush, mem_wb_flush,
    output mem_timeout_err, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use, redirect and
// data-memory wait handling with timeout flag and perf counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave h
);

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  logic mem_wait;
  logic hit1;
  logic hit2;
  logic load_use;
  logic do_wait;
  logic do_redir;
  logic do_lu;

  assign mem_wait = h.mem_req & ~h.mem_ready;
  assign hit1     = h.id_use_rs1 & (h.ex_rd == h.id_rs1);
  assign hit2     = h.id_use_rs2 & (h.ex_rd == h.id_rs2);
  assign load_use = h.ex_memread & (h.ex_rd != 5'd0)
                  & (hit1 | hit2);

  // One-hot priority terms: wait beats redirect beats load-use
  assign do_wait  = ~reset & mem_wait;
  assign do_redir = ~reset & ~mem_wait & h.ex_redirect;
  assign do_lu    = ~reset & ~mem_wait & ~h.ex_redirect
                  & load_use;

  always_comb begin
    h.pc_stall     = 1'b0;
    h.if_id_stall  = 1'b0;
    h.id_ex_stall  = 1'b0;
    h.ex_mem_stall = 1'b0;
    h.if_id_flush  = 1'b0;
    h.id_ex_flush  = 1'b0;
    h.mem_wb_flush = 1'b0;
    unique case (1'b1)
      do_wait: begin
        h.pc_stall     = 1'b1;
        h.if_id_stall  = 1'b1;
        h.id_ex_stall  = 1'b1;
        h.ex_mem_stall = 1'b1;
        h.mem_wb_flush = 1'b1;
      end
      do_redir: begin
        h.if_id_flush = 1'b1;
        h.id_ex_flush = 1'b1;
      end
      do_lu: begin
        h.pc_stall    = 1'b1;
        h.if_id_stall = 1'b1;
        h.id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_RUN;
      wait_cnt          <= 8'd0;
      h.mem_timeout_err <= 1'b0;
      h.stall_cycles    <= 32'd0;
      h.flush_events    <= 32'd0;
    end else begin
      case (state)
        S_RUN: begin
          wait_cnt <= 8'd0;
          if (mem_wait)
            state <= S_WAIT;
        end
        default: begin
          if (wait_cnt != 8'hFF)
            wait_cnt <= wait_cnt + 8'd1;
          if (wait_cnt == TO_CNT && !h.mem_ready)
            h.mem_timeout_err <= 1'b1;
          if (h.mem_ready || !h.mem_req)
            state <= S_RUN;
        end
      endcase
      if (h.pc_stall)
        h.stall_cycles <= h.stall_cycles + 32'd1;
      if (h.if_id_flush)
        h.flush_events <= h.flush_events + 32'd1;
    end
  end

endmodule
